// File: rtl/mist1032sa_cdc_handshake_tx.sv
// Source side of a 4-phase req/ack clock-domain crossing: holds one word on the
// crossing bus, raises a level request and sequences it against a synchronized ack.
module mist1032sa_cdc_handshake_tx #(
  parameter int N       = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic         iCLOCK,
  input  logic         iRESET_SYNC,
  input  logic         iSEND_VALID,
  output logic         oSEND_READY,
  input  logic [N-1:0] iSEND_DATA,
  output logic         oSEND_DONE,
  output logic         oSEND_ERROR,
  output logic         oCDC_REQ,
  output logic [N-1:0] oCDC_DATA,
  input  logic         iCDC_ACK
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } state_t;

  localparam logic [15:0] LP_TIMEOUT    = 16'(TIMEOUT);
  localparam bit          LP_TIMEOUT_EN = (TIMEOUT != 0);

  state_t       r_state, w_state_next;
  logic         r_ack_s0, r_ack_s1;
  logic [15:0]  r_timer, w_timer_next, w_timer_inc;
  logic         r_aborted, w_aborted_next;
  logic         r_req, w_req_next;
  logic [N-1:0] r_data, w_data_next;
  logic         r_done, w_done_next;
  logic         r_error, w_error_next;
  logic         w_timeout;

  assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;
  assign w_timeout   = LP_TIMEOUT_EN && (r_timer == LP_TIMEOUT);

  // The ack arrives from another clock domain, so only the second flop is ever used.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_ack_s0 <= 1'b0;
      r_ack_s1 <= 1'b0;
    end else begin
      r_ack_s0 <= iCDC_ACK;
      r_ack_s1 <= r_ack_s0;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_state   <= IDLE;
      r_timer   <= 16'd0;
      r_aborted <= 1'b0;
      r_req     <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_aborted <= w_aborted_next;
      r_req     <= w_req_next;
      r_data    <= w_data_next;
      r_done    <= w_done_next;
      r_error   <= w_error_next;
    end
  end

  // An ack seen in the same cycle as the timeout wins, so a late but valid
  // handshake is never reported as an abort.
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = 16'd0;
    w_aborted_next = r_aborted;
    w_req_next     = r_req;
    w_data_next    = r_data;
    w_done_next    = 1'b0;
    w_error_next   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (iSEND_VALID) begin
          w_data_next  = iSEND_DATA;
          w_req_next   = 1'b1;
          w_state_next = REQ_HIGH;
        end
      end
      REQ_HIGH: begin
        w_timer_next = w_timer_inc;
        if (r_ack_s1) begin
          w_req_next     = 1'b0;
          w_timer_next   = 16'd0;
          w_aborted_next = 1'b0;
          w_state_next   = REQ_LOW;
        end else if (w_timeout) begin
          w_req_next     = 1'b0;
          w_timer_next   = 16'd0;
          w_aborted_next = 1'b1;
          w_state_next   = REQ_LOW;
        end
      end
      REQ_LOW: begin
        w_timer_next = w_timer_inc;
        if (!r_ack_s1) begin
          w_timer_next = 16'd0;
          w_done_next  = !r_aborted;
          w_error_next = r_aborted;
          w_state_next = IDLE;
        end else if (w_timeout) begin
          w_timer_next = 16'd0;
          w_error_next = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign oSEND_READY = (r_state == IDLE);
  assign oSEND_DONE  = r_done;
  assign oSEND_ERROR = r_error;
  assign oCDC_REQ    = r_req;
  assign oCDC_DATA   = r_data;

endmodule
